// File: rtl/gobou_img_fetch_if.sv
// Bundle of request, RAM-address and output-stream signals for the gobou image fetcher.
// The slave modport is the fetcher; the master modport is the host/RAM/datapath side.
interface gobou_img_fetch_if #(
    parameter int DWIDTH  = 16,
    parameter int IMGSIZE = 12
);
    logic                      req;
    logic [IMGSIZE-1:0]        base_addr;
    logic [IMGSIZE:0]          count;
    logic                      busy;
    logic                      done;
    logic [IMGSIZE-1:0]        mem_addr;
    logic signed [DWIDTH-1:0]  mem_rdata;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [DWIDTH-1:0]  out_data;

    modport slave (
        input  req, base_addr, count, mem_rdata, out_ready,
        output busy, done, mem_addr, out_valid, out_data
    );

    modport master (
        output req, base_addr, count, mem_rdata, out_ready,
        input  busy, done, mem_addr, out_valid, out_data
    );
endinterface

// File: rtl/gobou_img_fetch.sv
// Streams `count` words from the image RAM, starting at `base_addr`, onto a valid/ready
// stream through a 2-entry FIFO that absorbs the RAM's one-cycle read latency.
module gobou_img_fetch #(
    parameter int DWIDTH  = 16,
    parameter int IMGSIZE = 12
) (
    input  logic               clk,
    input  logic               rst,
    gobou_img_fetch_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [IMGSIZE-1:0]        addr_q, addr_d;
    logic [IMGSIZE:0]          issue_cnt_q, issue_cnt_d;
    logic [IMGSIZE:0]          deliv_cnt_q, deliv_cnt_d;
    logic                      done_q, done_d;
    logic                      inflight_q;
    logic signed [DWIDTH-1:0]  head_q, head_d;
    logic signed [DWIDTH-1:0]  tail_q, tail_d;
    logic [1:0]                occ_q, occ_d;

    logic                      push;
    logic                      pop;
    logic                      issue;
    logic [2:0]                level;

    assign push  = inflight_q;
    assign pop   = (occ_q != 2'd0) && bus.out_ready;
    assign level = {1'b0, occ_q} + {2'b00, inflight_q};
    // Words already held or on their way, less the one leaving now, must leave room for one more.
    assign issue = (state_q == FETCH) && (issue_cnt_q != '0) && (level < (3'd2 + {2'b00, pop}));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        deliv_cnt_d = deliv_cnt_q;
        done_d      = 1'b0;

        if (pop) begin
            deliv_cnt_d = deliv_cnt_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (bus.count != '0) begin
                        state_d     = FETCH;
                        addr_d      = bus.base_addr;
                        issue_cnt_d = bus.count;
                        deliv_cnt_d = bus.count;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (issue) begin
                    addr_d      = addr_q + 1'b1;
                    issue_cnt_d = issue_cnt_q - 1'b1;
                    if (issue_cnt_q == {{IMGSIZE{1'b0}}, 1'b1}) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && (deliv_cnt_q == {{IMGSIZE{1'b0}}, 1'b1})) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = bus.mem_rdata;
                else               tail_d = bus.mem_rdata;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = bus.mem_rdata;
                end else begin
                    head_d = tail_q;
                    tail_d = bus.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            deliv_cnt_q <= '0;
            done_q      <= 1'b0;
            inflight_q  <= 1'b0;
            occ_q       <= 2'd0;
            // NOTE: the FIFO data registers are reset too because out_data must read 0 after reset.
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            deliv_cnt_q <= deliv_cnt_d;
            done_q      <= done_d;
            inflight_q  <= issue;
            occ_q       <= occ_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.mem_addr  = addr_q;
    assign bus.out_valid = (occ_q != 2'd0);
    assign bus.out_data  = head_q;
endmodule

// File: tb/tb_gobou_img_fetch.sv
// Directed bench for gobou_img_fetch: a queue-based stream model checked every cycle,
// plus literal expectations for latency, wrap, zero-count, ignore-while-busy and reset.
module tb_gobou_img_fetch;
    localparam int DW = 16;
    localparam int AW = 12;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst;

    gobou_img_fetch_if #(.DWIDTH(DW), .IMGSIZE(AW)) bus ();

    gobou_img_fetch #(.DWIDTH(DW), .IMGSIZE(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic signed [DW-1:0] ram [DEPTH];

    int errors = 0;
    int checks = 0;

    logic signed [DW-1:0] exp_q [$];
    logic signed [DW-1:0] got [$];
    int   remaining  = 0;
    bit   model_busy = 0;
    bit   exp_done   = 0;
    bit   prev_stall = 0;
    logic signed [DW-1:0] prev_data;
    int   done_cnt   = 0;
    int   ready_mode = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM with one cycle of latency.
    always @(posedge clk) bus.mem_rdata <= ram[bus.mem_addr];

    always @(posedge clk) begin
        #1;
        if (rst || ready_mode == 0) bus.out_ready = 1'b1;
        else if (ready_mode == 1)   bus.out_ready = ~bus.out_ready;
        else                        bus.out_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Each negedge: check what the last edge produced, then predict what the next edge does.
    always @(negedge clk) begin
        bit busy_now;
        if (rst) begin
            exp_q.delete();
            model_busy = 0;
            exp_done   = 0;
            prev_stall = 0;
            remaining  = 0;
        end else begin
            check("done", {31'd0, bus.done}, {31'd0, exp_done});
            check("busy", {31'd0, bus.busy}, {31'd0, model_busy});
            check("fifo_overflow", {31'd0, dut.inflight_q && (dut.occ_q == 2'd2)}, 32'd0);
            if (bus.done) done_cnt++;
            if (prev_stall) begin
                check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
                check("stall_data", 32'(bus.out_data), 32'(prev_data));
            end
            busy_now = model_busy;
            exp_done = 0;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", {31'd0, bus.out_valid}, 32'd0);
                end else begin
                    check("data", 32'(bus.out_data), 32'(exp_q[0]));
                    if (bus.out_ready) begin
                        got.push_back(bus.out_data);
                        void'(exp_q.pop_front());
                        remaining--;
                        if (remaining == 0) begin
                            model_busy = 0;
                            exp_done   = 1;
                        end
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (bus.req && !busy_now) begin
                if (bus.count == '0) begin
                    exp_done = 1;
                end else begin
                    model_busy = 1;
                    remaining  = int'(bus.count);
                    for (int k = 0; k < int'(bus.count); k++)
                        exp_q.push_back(ram[(int'(bus.base_addr) + k) % DEPTH]);
                end
            end
        end
    end

    task automatic start(input logic [AW-1:0] base, input logic [AW:0] cnt);
        @(posedge clk); #1;
        bus.req = 1'b1; bus.base_addr = base; bus.count = cnt;
        @(posedge clk); #1;
        bus.req = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (!model_busy && exp_q.size() == 0 && !bus.busy) ok = 1;
        end
        check("timeout", {31'd0, ok}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int d0;
        bit reached;
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(3 * i);
        rst = 1'b1; bus.req = 1'b0; bus.base_addr = '0; bus.count = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Basic stream with literal cycle-by-cycle timing.
        ready_mode = 0; got.delete();
        start(12'h010, 13'd4);
        @(negedge clk);
        check("t1_e0_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t1_e0_addr", 32'(bus.mem_addr), 32'h010);
        @(negedge clk);
        check("t1_e1_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t1_e1_addr", 32'(bus.mem_addr), 32'h011);
        @(negedge clk);
        check("t1_w0", 32'({bus.out_valid, 16'(bus.out_data)}), 32'h10030);
        @(negedge clk);
        check("t1_w1", 32'({bus.out_valid, 16'(bus.out_data)}), 32'h10033);
        @(negedge clk);
        check("t1_w2", 32'({bus.out_valid, 16'(bus.out_data)}), 32'h10036);
        @(negedge clk);
        check("t1_w3", 32'({bus.out_valid, 16'(bus.out_data)}), 32'h10039);
        @(negedge clk);
        check("t1_done", {31'd0, bus.done}, 32'd1);
        check("t1_busy", {31'd0, bus.busy}, 32'd0);
        check("t1_valid_end", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        check("t1_done_pulse", {31'd0, bus.done}, 32'd0);
        check("t1_words", 32'(got.size()), 32'd4);

        // Toggling backpressure.
        ready_mode = 1; got.delete();
        start(12'h010, 13'd4);
        wait_done(100);
        check("t2_words", 32'(got.size()), 32'd4);
        if (got.size() == 4) check("t2_last", 32'(got[3]), 32'h39);

        // Address wrap.
        ready_mode = 0; got.delete();
        start(12'hFFE, 13'd4);
        wait_done(100);
        check("t3_words", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            check("t3_w0", 32'(got[0]), 32'h2FFA);
            check("t3_w2", 32'(got[2]), 32'h0);
            check("t3_w3", 32'(got[3]), 32'h3);
        end

        // Zero count.
        got.delete();
        start(12'h123, 13'd0);
        @(negedge clk);
        check("t4_done", {31'd0, bus.done}, 32'd1);
        check("t4_busy", {31'd0, bus.busy}, 32'd0);
        check("t4_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        check("t4_done_pulse", {31'd0, bus.done}, 32'd0);
        check("t4_words", 32'(got.size()), 32'd0);

        // Request while busy is ignored.
        got.delete(); d0 = done_cnt;
        start(12'h010, 13'd4);
        bus.req = 1'b1; bus.base_addr = 12'h100; bus.count = 13'd2;
        @(posedge clk); #1 bus.req = 1'b0;
        wait_done(100);
        check("t5_words", 32'(got.size()), 32'd4);
        if (got.size() == 4) check("t5_w0", 32'(got[0]), 32'h30);
        check("t5_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Reset mid-fetch, then a fresh request.
        got.delete(); d0 = done_cnt; reached = 0;
        start(12'h020, 13'd8);
        for (int i = 0; i < 20 && !reached; i++) begin
            @(negedge clk);
            if (got.size() >= 2) reached = 1;
        end
        check("t6_reach2", {31'd0, reached}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("t6_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t6_rst_data", 32'(bus.out_data), 32'd0);
        check("t6_rst_addr", 32'(bus.mem_addr), 32'd0);
        check("t6_rst_done", {31'd0, bus.done}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);
        got.delete();
        start(12'h040, 13'd3);
        wait_done(100);
        check("t6_words", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            check("t6_w0", 32'(got[0]), 32'hC0);
            check("t6_w2", 32'(got[2]), 32'hC6);
        end

        // Whole RAM with random backpressure.
        ready_mode = 2; got.delete(); d0 = done_cnt;
        start(12'h800, 13'd4096);
        wait_done(20000);
        check("t7_words", 32'(got.size()), 32'd4096);
        if (got.size() == 4096) begin
            check("t7_w0", 32'(got[0]), 32'h1800);
            check("t7_w2047", 32'(got[2047]), 32'h2FFD);
            check("t7_w2048", 32'(got[2048]), 32'h0);
        end
        check("t7_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("t7_end_addr", 32'(bus.mem_addr), 32'h800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
